// File: rtl/fpmult_rr_arbiter.sv
// rtl/fpmult_rr_arbiter.sv - round-robin front end sharing one pipelined FPMult among NREQ requesters
module fpmult_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*32-1:0]          req_a,
    input  logic [NREQ*32-1:0]          req_b,
    output logic [31:0]                 mul_a,
    output logic [31:0]                 mul_b,
    input  logic [31:0]                 mul_z,
    input  logic [4:0]                  mul_flags,
    output logic                        rsp_valid,
    output logic [IDW-1:0]              rsp_id,
    output logic [31:0]                 rsp_z,
    output logic [4:0]                  rsp_flags,
    output logic                        busy,
    output logic [$clog2(LAT+2)-1:0]    inflight
);

    localparam int CW = $clog2(LAT + 2);

    logic [IDW-1:0]          ptr;
    logic                    gnt_any;
    logic [IDW-1:0]          gid;
    logic [LAT:0]            tag_v;
    logic [LAT:0][IDW-1:0]   tag_id;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    // First valid requester at or above the pointer, wrapping; nothing while held or in reset.
    always_comb begin
        gnt_any = 1'b0;
        gid     = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!gnt_any && req_valid[wrap_idx(ptr, off)]) begin
                gnt_any = 1'b1;
                gid     = wrap_idx(ptr, off);
            end
        end
        if (!rst || hold) begin
            gnt_any = 1'b0;
            gid     = '0;
        end
    end

    assign req_ready = gnt_any ? (NREQ'(1) << gid) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            ptr      <= '0;
            tag_v    <= '0;
            tag_id   <= '0;
            inflight <= '0;
        end else begin
            if (gnt_any) begin
                mul_a <= req_a[32*gid +: 32];
                mul_b <= req_b[32*gid +: 32];
                ptr   <= (int'(gid) == NREQ - 1) ? '0 : gid + IDW'(1);
            end
            // Tag pipe shifts every cycle since the multiplier never stalls.
            tag_v  <= {tag_v[LAT-1:0], gnt_any};
            tag_id <= {tag_id[LAT-1:0], gid};
            case ({gnt_any, tag_v[LAT]})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign rsp_valid = tag_v[LAT];
    assign rsp_id    = tag_id[LAT];
    assign rsp_z     = mul_z;
    assign rsp_flags = mul_flags;
    assign busy      = (inflight != '0);

endmodule

// File: tb/tb_fpmult_rr_arbiter.sv
// tb/tb_fpmult_rr_arbiter.sv - self-checking bench for fpmult_rr_arbiter with a stand-in multiplier
module tb_fpmult_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 4;
    localparam int CW   = $clog2(LAT + 2);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [31:0]          mul_a, mul_b, mul_z;
    logic [4:0]           mul_flags;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_z;
    logic [4:0]           rsp_flags;
    logic                 busy;
    logic [CW-1:0]        inflight;

    always #5 clk = ~clk;

    fpmult_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_flags(mul_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_flags(rsp_flags),
        .busy(busy), .inflight(inflight)
    );

    // Stand-in multiplier: exact for 1.0*x and inf*0, an arbitrary mix otherwise.
    function automatic logic [36:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic a_inf, b_inf, a_zero, b_zero;
        a_inf  = (a[30:0] == 31'h7F800000);
        b_inf  = (b[30:0] == 31'h7F800000);
        a_zero = (a[30:0] == 31'h0);
        b_zero = (b[30:0] == 31'h0);
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {32'h7FC00000, 5'b10000};
        if (a == 32'h3F800000) return {b, 5'b00000};
        return {a ^ {b[15:0], b[31:16]}, a[4:0] ^ b[4:0]};
    endfunction

    logic [31:0] mp_a [LAT];
    logic [31:0] mp_b [LAT];
    logic [36:0] mres;
    always @(posedge clk) begin
        mp_a[0] <= mul_a;
        mp_b[0] <= mul_b;
        for (int i = 1; i < LAT; i++) begin
            mp_a[i] <= mp_a[i-1];
            mp_b[i] <= mp_b[i-1];
        end
    end
    assign mres      = fmul(mp_a[LAT-1], mp_b[LAT-1]);
    assign mul_z     = mres[36:5];
    assign mul_flags = mres[4:0];

    typedef struct {
        int          id;
        int          due;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        expq[$];
    int          mptr = 0;
    int          edges = 0;
    bit          armed = 1'b0;
    int          nchecks = 0;
    int          nerrs = 0;
    int          max_infl = 0;
    int          glog[$];
    int          rlog_id[$];
    int          rlog_edge[$];
    logic [31:0] rlog_z[$];
    logic [4:0]  rlog_f[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) edges++;

    // Model: queue of expected responses, each due LAT+1 edges after its grant edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        logic [36:0]     r;
        int              g;
        int              idx;
        g = -1;
        if (rst && !hold) begin
            for (int off = 0; off < NREQ; off++) begin
                idx = (mptr + off) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (armed) begin
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(er));
            check("inflight", 64'(inflight), 64'(expq.size()));
            check("busy", 64'(busy), 64'(expq.size() != 0));
            if (64'(inflight) > 64'(max_infl)) max_infl = int'(inflight);
            if (expq.size() > 0 && expq[0].due == edges) begin
                r = fmul(expq[0].a, expq[0].b);
                check("rsp_valid", 64'(rsp_valid), 64'(1));
                check("rsp_id", 64'(rsp_id), 64'(expq[0].id));
                check("rsp_z", 64'(rsp_z), 64'(r[36:5]));
                check("rsp_flags", 64'(rsp_flags), 64'(r[4:0]));
                void'(expq.pop_front());
            end else begin
                check("rsp_valid", 64'(rsp_valid), 64'(0));
            end
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
            if (rsp_valid) begin
                rlog_id.push_back(int'(rsp_id));
                rlog_edge.push_back(edges);
                rlog_z.push_back(rsp_z);
                rlog_f.push_back(rsp_flags);
            end
        end
        if (!rst) begin
            expq.delete();
            mptr  = 0;
            armed = 1'b1;
        end else if (armed && g >= 0) begin
            expq.push_back('{id: g, due: edges + 1 + LAT, a: req_a[32*g +: 32], b: req_b[32*g +: 32]});
            mptr = (g + 1) % NREQ;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        glog.delete();
        rlog_id.delete();
        rlog_edge.delete();
        rlog_z.delete();
        rlog_f.delete();
    endtask

    int t_start;

    initial begin
        rst = 1'b0; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        step(2);
        check("reset mul_a", 64'(mul_a), 64'(0));
        check("reset inflight", 64'(inflight), 64'(0));
        rst = 1'b1;

        // Single op 1.0 * 2.0 from requester 0
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        check("t1 busy after grant", 64'(busy), 64'(1));
        check("t1 mul_a", 64'(mul_a), 64'h3F800000);
        step(LAT);
        check("t1 rsp_valid", 64'(rsp_valid), 64'(1));
        check("t1 rsp_id", 64'(rsp_id), 64'(0));
        check("t1 rsp_z", 64'(rsp_z), 64'h40000000);
        check("t1 busy last", 64'(busy), 64'(1));
        step(1);
        check("t1 busy drop", 64'(busy), 64'(0));
        check("t1 rsp_valid drop", 64'(rsp_valid), 64'(0));

        // Grant to requester 3 wraps the pointer back to 0
        req_valid = 4'b1000;
        step(1);
        req_valid = '0;
        step(LAT + 2);

        // All requesters continuously valid
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'h11110000 * (i + 1) + i;
            req_b[32*i +: 32] = 32'h01020304 + 32'h00100000 * i;
        end
        clear_logs(); max_infl = 0; t_start = edges;
        req_valid = 4'b1111;
        step(8);
        req_valid = '0;
        step(LAT + 3);
        check("t2 grant count", 64'(glog.size()), 64'(8));
        check("t2 rsp count", 64'(rlog_id.size()), 64'(8));
        for (int i = 0; i < 8 && i < glog.size(); i++) check("t2 grant order", 64'(glog[i]), 64'(i % 4));
        for (int i = 0; i < 8 && i < rlog_id.size(); i++) check("t2 rsp order", 64'(rlog_id[i]), 64'(i % 4));
        if (rlog_edge.size() > 0) check("t2 first rsp edge", 64'(rlog_edge[0] - t_start), 64'(1 + LAT));
        check("t2 inflight peak", 64'(max_infl), 64'(5));

        // Only requesters 1 and 3
        clear_logs();
        req_valid = 4'b1010;
        step(4);
        req_valid = 4'b0101;
        #1;
        check("t3 wrap to 0", 64'(req_ready), 64'(4'b0001));
        step(1);
        req_valid = '0;
        check("t3 grant count", 64'(glog.size()), 64'(5));
        for (int i = 0; i < 5 && i < glog.size(); i++) check("t3 grant order", 64'(glog[i]), 64'((i == 4) ? 0 : ((i % 2) ? 3 : 1)));
        step(LAT + 2);

        // hold with two ops in flight
        req_valid = 4'b0011;
        step(1);
        req_valid = 4'b0001;
        step(1);
        check("t4 inflight", 64'(inflight), 64'(2));
        clear_logs();
        hold = 1'b1; req_valid = 4'b0100;
        step(8);
        check("t4 ready held", 64'(req_ready), 64'(0));
        check("t4 rsp count", 64'(rlog_id.size()), 64'(2));
        check("t4 inflight drained", 64'(inflight), 64'(0));
        check("t4 grants during hold", 64'(glog.size()), 64'(0));
        hold = 1'b0;
        #1;
        check("t4 release grant", 64'(req_ready), 64'(4'b0100));
        step(1);
        req_valid = '0;
        step(LAT + 2);

        // Reset with three ops in flight
        req_valid = 4'b1111;
        step(3);
        req_valid = '0; rst = 1'b0;
        step(1);
        rst = 1'b1;
        clear_logs();
        check("t5 inflight cleared", 64'(inflight), 64'(0));
        step(10);
        check("t5 no responses", 64'(rlog_id.size()), 64'(0));
        req_valid = 4'b0101;
        #1;
        check("t5 pointer reset", 64'(req_ready), 64'(4'b0001));
        step(1);
        req_valid = '0;
        step(LAT + 2);

        // Normal op then inf*0 back to back
        clear_logs();
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40400000; req_valid = 4'b0001;
        step(1);
        req_a[31:0] = 32'h7F800000; req_b[31:0] = 32'h00000000;
        step(1);
        req_valid = '0;
        step(LAT + 3);
        check("t6 rsp count", 64'(rlog_id.size()), 64'(2));
        if (rlog_id.size() == 2) begin
            check("t6 consecutive", 64'(rlog_edge[1] - rlog_edge[0]), 64'(1));
            check("t6 z0", 64'(rlog_z[0]), 64'h40400000);
            check("t6 z1 nan", 64'(rlog_z[1]), 64'h7FC00000);
            check("t6 flags1", 64'(rlog_f[1]), 64'(5'b10000));
            check("t6 id1", 64'(rlog_id[1]), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
